// File: rtl/branch_target_buffer_sa_pkg.sv
// Shared types and address-field helpers for the set-associative BTB.
// The typedefs describe the default geometry (64 entries, 2 ways, 32-bit PC).
package BtbTypes;

  localparam int BTB_ENTRY_NUM = 64;
  localparam int BTB_WAY_NUM   = 2;
  localparam int BTB_PC_WIDTH  = 32;
  localparam int BTB_SETS      = BTB_ENTRY_NUM / BTB_WAY_NUM;
  localparam int BTB_IDX_W     = $clog2(BTB_SETS);
  localparam int BTB_TAG_W     = BTB_PC_WIDTH - BTB_IDX_W - 2;

  typedef logic [BTB_IDX_W-1:0] BtbIndex;
  typedef logic [BTB_TAG_W-1:0] BtbTag;

  typedef struct packed {
    logic                    valid;
    BtbTag                   tag;
    logic [BTB_PC_WIDTH-1:0] target;
`ifdef BRANCH_TARGET_BUFFER_HYSTERESIS_EN
    logic [1:0]              counter;
`endif
  } BtbEntry;

  // Geometry-independent field extraction; callers cast to their own widths.
  function automatic logic [63:0] btbIndexOf(input logic [63:0] pc, input int idxW);
    return (pc >> 2) & ((64'd1 << idxW) - 64'd1);
  endfunction

  function automatic logic [63:0] btbTagOf(input logic [63:0] pc, input int idxW);
    return pc >> (idxW + 2);
  endfunction

endpackage

// File: rtl/branch_target_buffer_sa_victim_select.sv
// Per-set replacement choice: lowest invalid way first, else the round-robin pointer.
module btb_victim_select #(
  parameter int WAY_NUM = 2,
  parameter int WIDX    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WAY_NUM-1:0] i_valid,
  input  logic               i_advance,
  input  logic               i_flush,
  output logic [WIDX-1:0]    o_way
);

  logic            w_freeFound;
  logic [WIDX-1:0] w_freeWay;
  logic [WIDX-1:0] w_ptr;

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    w_freeFound = 1'b0;
    w_freeWay   = '0;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (!i_valid[w]) begin
        w_freeFound = 1'b1;
        w_freeWay   = WIDX'(w);
      end
    end
  end

  assign o_way = w_freeFound ? w_freeWay : w_ptr;

  generate
    if (WAY_NUM == 1) begin : g_direct
      assign w_ptr = '0;
    end else begin : g_roundRobin
      logic [WIDX-1:0] r_ptr;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_ptr <= '0;
        end else if (i_flush) begin
          r_ptr <= '0;
        end else if (i_advance) begin
          r_ptr <= (r_ptr == WIDX'(WAY_NUM - 1)) ? '0 : r_ptr + WIDX'(1);
        end
      end
      assign w_ptr = r_ptr;
    end
  endgenerate

endmodule

// File: rtl/branch_target_buffer_sa.sv
// Set-associative branch target buffer with registered lookup and round-robin fill.
// Optional 2-bit hysteresis counters per entry: define BRANCH_TARGET_BUFFER_HYSTERESIS_EN.
module branch_target_buffer_sa
  import BtbTypes::*;
#(
  parameter int ENTRY_NUM = 64,
  parameter int WAY_NUM   = 2,
  parameter int PC_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] npc,
  input  logic                stall,
  output logic                btbHit,
  output logic [PC_WIDTH-1:0] btbPredictedPc,
  input  logic                updateValid,
  input  logic [PC_WIDTH-1:0] updatePc,
  input  logic [PC_WIDTH-1:0] updateTarget,
  input  logic                updateTaken,
  input  logic                flush
);

  localparam int SETS = ENTRY_NUM / WAY_NUM;
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = PC_WIDTH - IDX - 2;
  localparam int WIDX = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

  logic [WAY_NUM-1:0]  r_valid  [SETS];
  logic [TAGW-1:0]     r_tag    [SETS][WAY_NUM];
  logic [PC_WIDTH-1:0] r_target [SETS][WAY_NUM];
`ifdef BRANCH_TARGET_BUFFER_HYSTERESIS_EN
  logic [1:0]          r_cnt    [SETS][WAY_NUM];
  logic [1:0]          w_upCnt;
`endif

  logic                r_hit;
  logic [PC_WIDTH-1:0] r_pred;

  logic [IDX-1:0]      w_lkIdx, w_upIdx;
  logic [TAGW-1:0]     w_lkTag, w_upTag;
  logic                w_lkHit;
  logic [PC_WIDTH-1:0] w_lkTarget;
  logic                w_upMatch;
  logic [WIDX-1:0]     w_upWay, w_wrWay;
  logic                w_alloc, w_wrData;
  logic [WIDX-1:0]     w_victim [SETS];

  assign w_lkIdx = IDX'(btbIndexOf(64'(npc), IDX));
  assign w_lkTag = TAGW'(btbTagOf(64'(npc), IDX));
  assign w_upIdx = IDX'(btbIndexOf(64'(updatePc), IDX));
  assign w_upTag = TAGW'(btbTagOf(64'(updatePc), IDX));

  // Lookup reads the pre-edge array, which gives read-before-write on collisions.
  always_comb begin
    w_lkHit    = 1'b0;
    w_lkTarget = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (r_valid[w_lkIdx][w] && (r_tag[w_lkIdx][w] == w_lkTag)
`ifdef BRANCH_TARGET_BUFFER_HYSTERESIS_EN
          && r_cnt[w_lkIdx][w][1]
`endif
         ) begin
        w_lkHit    = 1'b1;
        w_lkTarget = r_target[w_lkIdx][w];
      end
    end
  end

  always_comb begin
    w_upMatch = 1'b0;
    w_upWay   = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (r_valid[w_upIdx][w] && (r_tag[w_upIdx][w] == w_upTag)) begin
        w_upMatch = 1'b1;
        w_upWay   = WIDX'(w);
      end
    end
  end

`ifdef BRANCH_TARGET_BUFFER_HYSTERESIS_EN
  assign w_upCnt = r_cnt[w_upIdx][w_upWay];
`endif

  assign w_wrData = updateValid && updateTaken && !flush;
  assign w_alloc  = w_wrData && !w_upMatch;
  assign w_wrWay  = w_upMatch ? w_upWay : w_victim[w_upIdx];

  generate
    for (genvar s = 0; s < SETS; s++) begin : g_set
      btb_victim_select #(
        .WAY_NUM (WAY_NUM),
        .WIDX    (WIDX)
      ) u_victim (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (r_valid[s]),
        .i_advance (w_alloc && (w_upIdx == IDX'(s))),
        .i_flush   (flush),
        .o_way     (w_victim[s])
      );
    end
  endgenerate

  // Valid bits (and counters) carry reset; tag and target storage does not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
`ifdef BRANCH_TARGET_BUFFER_HYSTERESIS_EN
        for (int w = 0; w < WAY_NUM; w++) begin
          r_cnt[s][w] <= '0;
        end
`endif
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
      end
    end else if (updateValid) begin
      if (updateTaken) begin
        r_valid[w_upIdx][w_wrWay] <= 1'b1;
`ifdef BRANCH_TARGET_BUFFER_HYSTERESIS_EN
        if (!w_upMatch) begin
          r_cnt[w_upIdx][w_wrWay] <= 2'd2;
        end else if (w_upCnt != 2'd3) begin
          r_cnt[w_upIdx][w_wrWay] <= w_upCnt + 2'd1;
        end
`endif
      end else if (w_upMatch) begin
`ifdef BRANCH_TARGET_BUFFER_HYSTERESIS_EN
        if (w_upCnt != 2'd0) begin
          r_cnt[w_upIdx][w_upWay] <= w_upCnt - 2'd1;
        end
`else
        r_valid[w_upIdx][w_upWay] <= 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wrData) begin
      r_tag[w_upIdx][w_wrWay]    <= w_upTag;
      r_target[w_upIdx][w_wrWay] <= updateTarget;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit  <= 1'b0;
      r_pred <= '0;
    end else if (flush) begin
      r_hit  <= 1'b0;
      r_pred <= '0;
    end else if (!stall) begin
      r_hit  <= w_lkHit;
      r_pred <= w_lkTarget;
    end
  end

  assign btbHit         = r_hit;
  assign btbPredictedPc = r_pred;

endmodule

// File: tb/tb_branch_target_buffer_sa.sv
// Self-checking bench for branch_target_buffer_sa (default 64 entries, 2 ways, 32-bit PC).
// Directed scenarios followed by random traffic, all checked against a behavioural model.
module tb_branch_target_buffer_sa;

  localparam int SETS = 32;
  localparam int WAYS = 2;
  localparam int IDXB = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc;
  logic        stall;
  logic        btbHit;
  logic [31:0] btbPredictedPc;
  logic        updateValid;
  logic [31:0] updatePc;
  logic [31:0] updateTarget;
  logic        updateTaken;
  logic        flush;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Reference model: per-set way table plus a replacement pointer per set.
  bit          mValid  [SETS][WAYS];
  int unsigned mTag    [SETS][WAYS];
  logic [31:0] mTarget [SETS][WAYS];
  int          mPtr    [SETS];
`ifdef BRANCH_TARGET_BUFFER_HYSTERESIS_EN
  int          mCnt    [SETS][WAYS];
`endif
  logic        expHit;
  logic [31:0] expPc;

  always #5 clk = ~clk;

  branch_target_buffer_sa dut (
    .clk            (clk),
    .rst            (rst),
    .npc            (npc),
    .stall          (stall),
    .btbHit         (btbHit),
    .btbPredictedPc (btbPredictedPc),
    .updateValid    (updateValid),
    .updatePc       (updatePc),
    .updateTarget   (updateTarget),
    .updateTaken    (updateTaken),
    .flush          (flush)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int s = 0; s < SETS; s++) begin
      mPtr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        mValid[s][w] = 1'b0;
`ifdef BRANCH_TARGET_BUFFER_HYSTERESIS_EN
        mCnt[s][w] = 0;
`endif
      end
    end
    expHit = 1'b0;
    expPc  = '0;
  endfunction

  // One clock edge of the model: lookup sees the old table, then the update applies.
  function automatic void modelStep(input logic [31:0] lkPc, input logic st, input logic uv,
                                    input logic [31:0] upc, input logic [31:0] utgt,
                                    input logic utk, input logic fl);
    int unsigned s, t;
    int m, v;
    bit hitNow, cntOk;
    logic [31:0] tgtNow;
    s = (lkPc >> 2) % SETS;
    t = lkPc >> (2 + IDXB);
    hitNow = 1'b0;
    tgtNow = '0;
    for (int w = 0; w < WAYS; w++) begin
`ifdef BRANCH_TARGET_BUFFER_HYSTERESIS_EN
      cntOk = (mCnt[s][w] >= 2);
`else
      cntOk = 1'b1;
`endif
      if (mValid[s][w] && mTag[s][w] == t && cntOk) begin
        hitNow = 1'b1;
        tgtNow = mTarget[s][w];
      end
    end
    if (fl) begin
      for (int i = 0; i < SETS; i++) begin
        mPtr[i] = 0;
        for (int w = 0; w < WAYS; w++) mValid[i][w] = 1'b0;
      end
      expHit = 1'b0;
      expPc  = '0;
      return;
    end
    if (!st) begin
      expHit = hitNow;
      expPc  = tgtNow;
    end
    if (uv) begin
      s = (upc >> 2) % SETS;
      t = upc >> (2 + IDXB);
      m = -1;
      for (int w = 0; w < WAYS; w++)
        if (mValid[s][w] && mTag[s][w] == t) m = w;
      if (utk) begin
        if (m >= 0) begin
          mTarget[s][m] = utgt;
`ifdef BRANCH_TARGET_BUFFER_HYSTERESIS_EN
          if (mCnt[s][m] < 3) mCnt[s][m]++;
`endif
        end else begin
          v = -1;
          for (int w = WAYS - 1; w >= 0; w--)
            if (!mValid[s][w]) v = w;
          if (v < 0) v = mPtr[s];
          mValid[s][v]  = 1'b1;
          mTag[s][v]    = t;
          mTarget[s][v] = utgt;
`ifdef BRANCH_TARGET_BUFFER_HYSTERESIS_EN
          mCnt[s][v] = 2;
`endif
          mPtr[s] = (mPtr[s] + 1) % WAYS;
        end
      end else if (m >= 0) begin
`ifdef BRANCH_TARGET_BUFFER_HYSTERESIS_EN
        if (mCnt[s][m] > 0) mCnt[s][m]--;
`else
        mValid[s][m] = 1'b0;
`endif
      end
    end
  endfunction

  // Drive one cycle of inputs from the low phase, clock them in, then compare to the model.
  task automatic applyStimulus(input logic [31:0] aNpc, input logic aStall, input logic aUpV,
                               input logic [31:0] aUpPc, input logic [31:0] aUpTgt,
                               input logic aUpTk, input logic aFlush);
    npc          = aNpc;
    stall        = aStall;
    updateValid  = aUpV;
    updatePc     = aUpPc;
    updateTarget = aUpTgt;
    updateTaken  = aUpTk;
    flush        = aFlush;
    @(posedge clk);
    modelStep(aNpc, aStall, aUpV, aUpPc, aUpTgt, aUpTk, aFlush);
    #1;
    checkOutput("modelHit", btbHit, expHit);
    checkOutput("modelTarget", btbPredictedPc, expPc);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rPc, rUpPc;
    rst = 1'b0;
    npc = '0; stall = 1'b0; updateValid = 1'b0; updatePc = '0;
    updateTarget = '0; updateTaken = 1'b0; flush = 1'b0;
    modelReset();
    #2;
    checkOutput("resetHit", btbHit, 1'b0);
    checkOutput("resetTarget", btbPredictedPc, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] basic hit");
    applyStimulus(32'h0, 0, 1, 32'h1040, 32'h2000, 1, 0);
    applyStimulus(32'h1040, 0, 0, 0, 0, 0, 0);
    checkOutput("basicHit", btbHit, 1'b1);
    checkOutput("basicTarget", btbPredictedPc, 32'h2000);
    applyStimulus(32'h1044, 0, 0, 0, 0, 0, 0);
    checkOutput("neighbourMiss", btbHit, 1'b0);

    $display("[TB] conflict fill in set 16");
    applyStimulus(32'h0, 0, 1, 32'h1040, 32'hA000, 1, 0);
    applyStimulus(32'h0, 0, 1, 32'h2040, 32'hB000, 1, 0);
    applyStimulus(32'h0, 0, 1, 32'h3040, 32'hC000, 1, 0);
    applyStimulus(32'h2040, 0, 0, 0, 0, 0, 0);
    checkOutput("conflictHit2040", btbHit, 1'b1);
    checkOutput("conflictTgt2040", btbPredictedPc, 32'hB000);
    applyStimulus(32'h3040, 0, 0, 0, 0, 0, 0);
    checkOutput("conflictHit3040", btbHit, 1'b1);
    applyStimulus(32'h1040, 0, 0, 0, 0, 0, 0);
    checkOutput("conflictEvict1040", btbHit, 1'b0);

    $display("[TB] lookup/update collision");
    applyStimulus(32'h1040, 0, 1, 32'h1040, 32'h5000, 1, 0);
    checkOutput("collisionOld", btbHit, 1'b0);
    applyStimulus(32'h1040, 0, 0, 0, 0, 0, 0);
    checkOutput("collisionNewHit", btbHit, 1'b1);
    checkOutput("collisionNewTgt", btbPredictedPc, 32'h5000);

    $display("[TB] stall hold");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h9990, 1, 0, 0, 0, 0, 0);
      checkOutput("stallHit", btbHit, 1'b1);
      checkOutput("stallTgt", btbPredictedPc, 32'h5000);
    end

    $display("[TB] flush with concurrent update");
    applyStimulus(32'h1040, 0, 1, 32'h7040, 32'h1234, 1, 1);
    checkOutput("flushSameEdge", btbHit, 1'b0);
    applyStimulus(32'h1040, 0, 0, 0, 0, 0, 0);
    checkOutput("flushMiss1040", btbHit, 1'b0);
    applyStimulus(32'h3040, 0, 0, 0, 0, 0, 0);
    checkOutput("flushMiss3040", btbHit, 1'b0);
    applyStimulus(32'h7040, 0, 0, 0, 0, 0, 0);
    checkOutput("flushDroppedUpd", btbHit, 1'b0);

    $display("[TB] not-taken update");
    applyStimulus(32'h0, 0, 1, 32'h1040, 32'h6000, 1, 0);
    applyStimulus(32'h0, 0, 1, 32'h1040, 32'h6000, 0, 0);
    applyStimulus(32'h1040, 0, 0, 0, 0, 0, 0);
    checkOutput("notTakenMiss", btbHit, 1'b0);
    applyStimulus(32'h0, 0, 1, 32'h1040, 32'h6000, 1, 0);
    applyStimulus(32'h1040, 0, 0, 0, 0, 0, 0);
    checkOutput("retakenHit", btbHit, 1'b1);
    checkOutput("retakenTgt", btbPredictedPc, 32'h6000);

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(32'h0, 0, 1, 32'h2040, 32'h4444, 1, 0);
    npc = 32'h2040; updateValid = 1'b1; updatePc = 32'h3040;
    updateTarget = 32'h5555; updateTaken = 1'b1;
    #2 rst = 1'b0;
    #1;
    checkOutput("asyncResetHit", btbHit, 1'b0);
    checkOutput("asyncResetTgt", btbPredictedPc, 32'h0);
    modelReset();
    @(negedge clk);
    updateValid = 1'b0;
    rst = 1'b1;
    applyStimulus(32'h2040, 0, 0, 0, 0, 0, 0);
    checkOutput("resetClearedEntry", btbHit, 1'b0);
    applyStimulus(32'h3040, 0, 0, 0, 0, 0, 0);
    checkOutput("resetDroppedUpd", btbHit, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      rPc   = ($urandom_range(0, 5) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      rUpPc = ($urandom_range(0, 5) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      applyStimulus(rPc, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), rUpPc,
                    $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 60) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
